// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encoding and the width of the shared holding register.
package reg_arb_pkg;

    // Width of the shared holding register and of each requester's data word.
    localparam int DATA_W = 4;

    // Arbiter FSM encoding. 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // True for the states in which a transaction is in flight.
    function automatic logic is_busy_state(input state_t s);
        return (s == WRITE) || (s == ACK);
    endfunction

endpackage

// File: rtl/four_bit_register.sv
// Shared 4-bit holding register with synchronous reset and write enable.
// Reset has priority over enable, so a reset during a write clears q.
module four_bit_register
    import reg_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Register update: reset wins, otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one 4-bit holding register between
// N_REQ requesters. A grant is decided in IDLE, the latched data is written
// in WRITE, and the winner receives a one-cycle ack in ACK while q already
// shows its data. The round-robin pointer advances past the winner in ACK.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [DATA_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [DATA_W-1:0]          q
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [DATA_W-1:0] data_lat;
    logic              enable;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [DATA_W-1:0] req_word [N_REQ];

    // Round-robin pick: first set request bit at or after p, wrapping.
    // Returns {found, index}. Scanning from the lowest priority toward
    // the highest lets the last hit be the winner.
    function automatic logic [ID_W:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [ID_W-1:0]  p
    );
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ID_W'((int'(p) + k) % N_REQ);
            if (r[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx};
    endfunction

    // Split the flat data bus into one word per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[DATA_W*i +: DATA_W];
    end

    // Combinational winner selection from the live requests and pointer.
    always_comb begin
        {pick_found, pick_idx} = rr_pick(req, ptr);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = WRITE;
            WRITE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only; req never reaches ack
    // combinationally.
    always_comb begin
        enable = (state == WRITE);
        busy   = is_busy_state(state);
        ack    = '0;
        if (state == ACK) begin
            ack[grant_id] = 1'b1;
        end
    end

    // Grant capture in IDLE and pointer advance in ACK. Data is captured at
    // grant so later req_data changes cannot affect the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            grant_id <= '0;
            data_lat <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
                data_lat <= req_word[pick_idx];
            end
            if (state == ACK) begin
                ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
        end
    end

    four_bit_register u_reg (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (data_lat),
        .q      (q)
    );

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one 4-bit holding register between `N_REQ` requesters. Each requester raises a request with its data. The arbiter picks one winner, writes its data through the register's enable port, and acknowledges the winner once the value is visible on `q`. It sits between several control agents and a single shared 4-bit status/config register.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  N_REQ: request bit `i` from requester `i`, held high until `ack[i]`.
- `req_data`  input  4*N_REQ: requester `i` data occupies bits `[4*i+3:4*i]`.
- `ack`  output  N_REQ: one-cycle pulse to the winner; `q` already holds its data.
- `grant_id`  output  clog2(N_REQ): index of the current or most recent winner.
- `busy`  output  1: high while in WRITE or ACK.
- `q`  output  4: shared register contents.

## Operation
- FSM has three states: IDLE, WRITE, ACK.
- IDLE, `req` all zero: stay in IDLE.
- IDLE, any `req` set:
  - select the winner by round-robin, searching from `ptr` upward with wrap-around;
  - latch the winner's 4-bit data and index;
  - go to WRITE.
- WRITE: drive the register with `enable`=1 and `d`=latched data; go to ACK.
- ACK:
  - `ack[grant_id]`=1;
  - `ptr` <= (`grant_id`+1) mod `N_REQ`;
  - go to IDLE.
- `ptr` is the highest-priority index for the next arbitration. Reset value is 0.
- Data is captured at grant. Changes to `req_data` after the grant cycle do not affect the write.
- A requester dropping `req` after the grant does not cancel anything: the write and ack still occur.
- Requester rule: deassert `req` in the cycle after `ack`. If `req` is still high in that cycle, it is a new request and competes normally.
- Requests arriving during WRITE or ACK are ignored until the FSM returns to IDLE. They are not lost as long as `req` stays high.
- `enable` to the register is asserted only in WRITE, so `q` is otherwise stable.
- Reset values:
  - state = IDLE;
  - `ptr` = 0;
  - `q` = 4'b0000;
  - `ack` = 0;
  - `grant_id` = 0;
  - `busy` = 0.
- Reset mid-transaction (WRITE or ACK):
  - the transaction is aborted and no `ack` is issued;
  - `q` is forced to 0, because register reset has priority over enable;
  - the requester must keep `req` high to retry.

## Timing
- Cycle n: IDLE samples `req`; grant is decided and data latched at the edge ending cycle n.
- Cycle n+1: WRITE, `busy`=1, `enable`=1; `q` updates at the edge ending n+1.
- Cycle n+2: ACK, `ack` pulse, `q` = new data, `busy`=1.
- Cycle n+3: IDLE; earliest next grant decision.
- Latency from request to ack is 2 cycles. Maximum throughput is one write per 3 cycles.
- `grant_id` updates at the edge ending cycle n and holds until the next grant.
- All outputs are registered or decoded from registered state. There is no combinational path from `req` to `ack`.
- Fairness: a continuously asserted request is granted within `N_REQ` transactions.

## Structure
- Shared package `reg_arb_pkg` holds:
  - the state encoding constants IDLE=2'd0, WRITE=2'd1, ACK=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the data width constant 4.
- Sub-module: one `four_bit_register` instance, inputs driven as follows:
  - `clk` from `clk`;
  - `rst` from `rst`;
  - `enable` from the WRITE decode;
  - `d` from the latched data.
- The round-robin select is a combinational function, local to the block, of `req` and `ptr`.

## Test plan
- Reset: assert `rst` for 2 cycles with `req`=4'b1111 -> `q`=0, `ack`=0, `busy`=0, `grant_id`=0; after release, first grant goes to requester 0.
- Single request: `req`=4'b0100, data2=4'hA at cycle n -> `enable` high at n+1, `q`=4'hA and `ack`=4'b0100 at n+2, `busy` low at n+3.
- Round-robin: `req`=4'b1111 held, data i=4'h1+i, each `req` dropped after its ack -> acks in order 0,1,2,3; `q` sequence 1,2,3,4; ack every 3 cycles.
- Data change after grant: grant requester 1 with data 4'h5, then change data1 to 4'hF in WRITE -> `q`=4'h5.
- Pointer wrap and sticky request:
  - grant requester 3; in the same cycle `req`=4'b1001 with `req[3]` held after its ack;
  - -> next grant goes to 0, then 3 again.
- Reset during WRITE: `q` previously 4'h7, then `rst` in WRITE cycle -> no `ack`, `q`=0, state IDLE; the held `req` is re-granted after reset release.
